// File: rtl/npc_btb_if.sv
// Fetch-side bus of the next-PC / BTB block.
//   master : stall/redirect and training inputs, observes pc/prediction
//   slave  : the npc_btb block (consumes controls, produces pc/prediction)
// Signals:
//   stall_i, redirect_i, redirect_pc_i                    fetch control
//   upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i      BTB training
//   pc_o, pred_taken_o, pred_target_o                     fetch PC + prediction
interface npc_btb_if #(
  parameter int unsigned XLEN = 32
);
  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic [XLEN-1:0] pc_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;

  modport master (
    output stall_i, redirect_i, redirect_pc_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  pc_o, pred_taken_o, pred_target_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
    output pc_o, pred_taken_o, pred_target_o
  );
endinterface

// File: rtl/npc_btb.sv
// Next-PC generator with a direct-mapped branch target buffer.
// Ports:
//   clk  : clock, all state updates on rising edge
//   rstn : asynchronous active-low reset
//   bus  : npc_btb_if.slave (fetch control, training, pc/prediction)
// Each entry holds valid, tag, target and a 2-bit saturating counter.
// Prediction is combinational from the registered pc; training writes
// at most one entry per edge, indexed by the resolved branch PC.
module npc_btb #(
  parameter int unsigned    XLEN      = 32,
  parameter int unsigned    BTB_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic     clk,
  input  logic     rstn,
  npc_btb_if.slave bus
);
  localparam int unsigned IDX   = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX - 2;

  logic             valid_q  [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q    [BTB_DEPTH];
  logic [XLEN-1:0]  target_q [BTB_DEPTH];
  logic [1:0]       ctr_q    [BTB_DEPTH];

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  pc_d;

  // Lookup for the current fetch PC.
  logic [IDX-1:0]   rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_hit;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;

  always_comb begin
    rd_idx      = pc_q[IDX+1:2];
    rd_tag      = pc_q[XLEN-1:IDX+2];
    rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    pred_taken  = rd_hit && ctr_q[rd_idx][1];
    pred_target = pred_taken ? target_q[rd_idx] : '0;
  end

  assign bus.pc_o          = pc_q;
  assign bus.pred_taken_o  = pred_taken;
  assign bus.pred_target_o = pred_target;

  // Next-PC priority: redirect, stall, predicted taken, sequential.
  always_comb begin
    pc_d = pc_q + XLEN'(4);
    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (bus.stall_i) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Training side: index/tag from the resolved branch PC.
  logic [IDX-1:0]   wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;
  logic [1:0]       ctr_inc;
  logic [1:0]       ctr_dec;
  logic [XLEN-1:0]  wr_target;

  always_comb begin
    wr_idx    = bus.upd_pc_i[IDX+1:2];
    wr_tag    = bus.upd_pc_i[XLEN-1:IDX+2];
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    wr_target = {bus.upd_target_i[XLEN-1:2], 2'b00};
    ctr_inc   = (ctr_q[wr_idx] == 2'b11) ? 2'b11 : ctr_q[wr_idx] + 2'b01;
    ctr_dec   = (ctr_q[wr_idx] == 2'b00) ? 2'b00 : ctr_q[wr_idx] - 2'b01;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (bus.upd_valid_i) begin
      if (wr_hit) begin
        if (bus.upd_taken_i) begin
          ctr_q[wr_idx]    <= ctr_inc;
          target_q[wr_idx] <= wr_target;
        end else begin
          ctr_q[wr_idx]    <= ctr_dec;
        end
      end else if (bus.upd_taken_i) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        ctr_q[wr_idx]    <= 2'b10;
      end
    end
  end

  // Word-alignment bits of incoming addresses are dropped by design.
  logic unused_low_bits;
  assign unused_low_bits = ^{bus.redirect_pc_i[1:0], bus.upd_pc_i[1:0],
                             bus.upd_target_i[1:0]};
endmodule
